// File: rtl/execute_stage.sv
// Execute stage: predicated single-cycle ALU with Z/N flags, plus iterative
// 32-step MUL/DIV that stalls decode. All write-back requests are registered.
module execute_stage #(
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Aval,
    input  logic [31:0] Bval,
    input  logic [31:0] instructionExecute,
    output logic        stall,
    output logic        regWe,
    output logic [3:0]  regAddr,
    output logic [31:0] regData,
    output logic        ovfWe,
    output logic [31:0] ovfData,
    output logic        branch,
    output logic [31:0] branchTarget
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [4:0] OP_MOV = 5'd1,  OP_ADD = 5'd2,  OP_SUB = 5'd3,
                           OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,
                           OP_SHL = 5'd7,  OP_SHR = 5'd8,  OP_SRA = 5'd9,
                           OP_SLT = 5'd10, OP_MUL = 5'd11, OP_DIV = 5'd12;

    logic [4:0] opc;
    logic [3:0] rc;
    logic [2:0] cond;
    logic       cmp;
    logic       unused_instr;

    assign opc  = instructionExecute[12:8];
    assign rc   = instructionExecute[7:4];
    assign cond = instructionExecute[3:1];
    assign cmp  = instructionExecute[0];
    assign unused_instr = ^instructionExecute[31:13];

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        cap_mul_q, cap_cmp_q;
    logic [3:0]  cap_rc_q;
    logic        z_q, z_d, n_q, n_d;
    logic        reg_we_q, reg_we_d, ovf_we_q, ovf_we_d, br_q, br_d;
    logic [3:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_data_q, reg_data_d, ovf_data_q, ovf_data_d, br_tgt_q, br_tgt_d;

    logic cond_pass;
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cond_pass = 1'b0;
        case (cond)
            3'd0: cond_pass = 1'b1;
            3'd1: cond_pass = z_q;
            3'd2: cond_pass = !z_q;
            3'd3: cond_pass = n_q;
            3'd4: cond_pass = !n_q;
            3'd5: cond_pass = n_q | z_q;
            3'd6: cond_pass = !n_q & !z_q;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [32:0] add33, sub33;
    logic [31:0] alu_res, alu_side;
    logic        alu_fire, alu_side_en;
    assign add33 = {1'b0, Aval} + {1'b0, Bval};
    assign sub33 = {1'b0, Aval} - {1'b0, Bval};

    always_comb begin
        alu_res     = '0;
        alu_side    = '0;
        alu_fire    = 1'b1;
        alu_side_en = 1'b0;
        case (opc)
            OP_MOV: alu_res = Bval;
            OP_ADD: begin alu_res = add33[31:0]; alu_side = {31'd0, add33[32]}; alu_side_en = 1'b1; end
            OP_SUB: begin alu_res = sub33[31:0]; alu_side = {31'd0, sub33[32]}; alu_side_en = 1'b1; end
            OP_AND: alu_res = Aval & Bval;
            OP_OR:  alu_res = Aval | Bval;
            OP_XOR: alu_res = Aval ^ Bval;
            OP_SHL: alu_res = Aval << Bval[4:0];
            OP_SHR: alu_res = Aval >> Bval[4:0];
            OP_SRA: alu_res = $signed(Aval) >>> Bval[4:0];
            OP_SLT: alu_res = {31'd0, $signed(Aval) < $signed(Bval)};
            OP_DIV: begin
                // Divide by zero never enters the iterative unit.
                alu_fire    = MULDIV_EN && (Bval == 32'd0);
                alu_res     = 32'hFFFF_FFFF;
                alu_side    = Aval;
                alu_side_en = 1'b1;
            end
            default: alu_fire = 1'b0;
        endcase
    end

    logic start_md;
    assign start_md = MULDIV_EN && (state_q == IDLE) && cond_pass &&
                      ((opc == OP_MUL) || ((opc == OP_DIV) && (Bval != 32'd0)));
    assign stall = !rst && (start_md || (state_q == BUSY));

    // One multiply/divide step; the first step runs on the capture edge from the raw operands.
    logic        md_is_mul;
    logic [31:0] md_opnd;
    logic [63:0] md_acc, md_next;
    logic [32:0] mul_sum, div_shift, div_trial;
    always_comb begin
        if (state_q == IDLE) begin
            md_is_mul = (opc == OP_MUL);
            md_opnd   = md_is_mul ? Aval : Bval;
            md_acc    = md_is_mul ? {32'd0, Bval} : {32'd0, Aval};
        end else begin
            md_is_mul = cap_mul_q;
            md_opnd   = opnd_q;
            md_acc    = acc_q;
        end
        mul_sum   = {1'b0, md_acc[63:32]} + (md_acc[0] ? {1'b0, md_opnd} : 33'd0);
        div_shift = md_acc[63:31];
        div_trial = div_shift - {1'b0, md_opnd};
        if (md_is_mul)
            md_next = {mul_sum, md_acc[31:1]};
        else if (!div_trial[32])
            md_next = {div_trial[31:0], md_acc[30:0], 1'b1};
        else
            md_next = {div_shift[31:0], md_acc[30:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_md) begin state_d = BUSY; cnt_d = 6'd1; end
            BUSY: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DONE;
            end
            default: begin state_d = IDLE; cnt_d = 6'd0; end
        endcase
    end

    logic        wb_fire, wb_cmp, wb_side_en;
    logic [3:0]  wb_rc;
    logic [31:0] wb_res, wb_side;
    always_comb begin
        wb_fire    = 1'b0;
        wb_cmp     = cmp;
        wb_rc      = rc;
        wb_res     = alu_res;
        wb_side    = alu_side;
        wb_side_en = alu_side_en;
        if (state_q == DONE) begin
            wb_fire    = 1'b1;
            wb_cmp     = cap_cmp_q;
            wb_rc      = cap_rc_q;
            wb_res     = acc_q[31:0];
            wb_side    = acc_q[63:32];
            wb_side_en = 1'b1;
        end else if (state_q == IDLE) begin
            wb_fire = cond_pass && alu_fire;
        end

        reg_we_d   = 1'b0;
        ovf_we_d   = 1'b0;
        br_d       = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        ovf_data_d = ovf_data_q;
        br_tgt_d   = br_tgt_q;
        z_d        = z_q;
        n_d        = n_q;
        if (wb_fire) begin
            if (wb_rc <= 4'd13) begin
                reg_we_d = 1'b1; reg_addr_d = wb_rc; reg_data_d = wb_res;
            end else if (wb_rc == 4'd14) begin
                br_d = 1'b1; br_tgt_d = wb_res;
            end else begin
                ovf_we_d = 1'b1; ovf_data_d = wb_res;
            end
            if ((wb_rc != 4'd15) && wb_side_en) begin
                ovf_we_d = 1'b1; ovf_data_d = wb_side;
            end
            if (wb_cmp) begin
                z_d = (wb_res == 32'd0);
                n_d = wb_res[31];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            reg_we_q   <= 1'b0;
            ovf_we_q   <= 1'b0;
            br_q       <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            ovf_data_q <= '0;
            br_tgt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            z_q        <= z_d;
            n_q        <= n_d;
            reg_we_q   <= reg_we_d;
            ovf_we_q   <= ovf_we_d;
            br_q       <= br_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            ovf_data_q <= ovf_data_d;
            br_tgt_q   <= br_tgt_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before the FSM reads them.
    always_ff @(posedge clk) begin
        if (start_md || (state_q == BUSY)) acc_q <= md_next;
        if (start_md) begin
            opnd_q    <= md_opnd;
            cap_mul_q <= md_is_mul;
            cap_rc_q  <= rc;
            cap_cmp_q <= cmp;
        end
    end

    assign regWe        = reg_we_q;
    assign regAddr      = reg_addr_q;
    assign regData      = reg_data_q;
    assign ovfWe        = ovf_we_q;
    assign ovfData      = ovf_data_q;
    assign branch       = br_q;
    assign branchTarget = br_tgt_q;

endmodule
